// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory command-port arbiter: FSM encoding,
// SDRAM controller instruction codes and requester port indices.
package mem_port_arbiter_pkg;

    typedef logic [2:0] state_t;
    typedef logic [2:0] mem_instr_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_WDATA = 3'd1;
    localparam state_t S_ISSUE = 3'd2;
    localparam state_t S_RDATA = 3'd3;
    localparam state_t S_DONE  = 3'd4;

    localparam mem_instr_t MEM_INSTR_WR = 3'b000;
    localparam mem_instr_t MEM_INSTR_RD = 3'b001;

    localparam int PORT_CMD  = 0;
    localparam int PORT_DATA = 1;
    localparam int PORT_WGT  = 2;
    localparam int PORT_WB   = 3;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Round-robin picker: the first set request strictly after ptr, searched
// cyclically, is returned as a one-hot winner.
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     win,
    output logic             valid
);

    logic [PTR_W-1:0] idx;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        win = '0;
        idx = '0;
        // Walk from the farthest candidate to the nearest so the nearest set request overwrites.
        for (int k = N; k >= 1; k--) begin
            idx = PTR_W'((int'(ptr) + k) % N);
            if (req[idx]) win = N'(1) << idx;
        end
    end

    assign valid = |req;

endmodule

// File: rtl/mem_port_arbiter.sv
// Grants the single SDRAM command port to one requester per burst, issues the
// command, and counts data beats until the burst completes.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int ADDR_W  = 32,
    parameter int BL_W    = 6,
    parameter int PRIO0   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_PORTS-1:0]        req,
    input  logic [N_PORTS-1:0]        we,
    input  logic [N_PORTS*ADDR_W-1:0] addr,
    input  logic [N_PORTS*BL_W-1:0]   bl,
    output logic [N_PORTS-1:0]        gnt,
    output logic [N_PORTS-1:0]        done,
    output logic                      mem_cmd_en,
    output logic [2:0]                mem_cmd_instr,
    output logic [ADDR_W-1:0]         mem_cmd_addr,
    output logic [BL_W-1:0]           mem_cmd_bl,
    input  logic                      mem_cmd_full,
    input  logic                      mem_wr_beat,
    input  logic                      mem_rd_beat,
    output logic                      busy,
    output logic                      err
);

    localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    state_t               state;
    mem_instr_t           instr_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [BL_W-1:0]      bl_q;
    logic [BL_W-1:0]      beat_cnt;
    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     idx_q;
    logic [PTR_W-1:0]     win_idx;
    logic [N_PORTS-1:0]   rr_req;
    logic [N_PORTS-1:0]   rr_win;
    logic [N_PORTS-1:0]   win;
    logic                 rr_valid;
    logic                 prio_hit;
    logic                 any_req;
    logic                 beat_err;

    // Port 0 bypasses the rotation when it has fixed priority.
    always_comb begin
        rr_req = req;
        if (PRIO0 != 0) rr_req[PORT_CMD] = 1'b0;
    end

    rr_pick #(.N(N_PORTS), .PTR_W(PTR_W)) u_rr_pick (
        .req   (rr_req),
        .ptr   (ptr),
        .win   (rr_win),
        .valid (rr_valid)
    );

    assign prio_hit = (PRIO0 != 0) && req[PORT_CMD];
    assign win      = prio_hit ? N_PORTS'(1) : rr_win;
    assign any_req  = prio_hit || rr_valid;

    always_comb begin
        win_idx = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (win[i]) win_idx = PTR_W'(i);
        end
    end

    assign beat_err = (mem_wr_beat && state != S_WDATA)
                   || (mem_rd_beat && state != S_RDATA)
                   || (mem_wr_beat && mem_rd_beat);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            gnt      <= '0;
            instr_q  <= MEM_INSTR_WR;
            addr_q   <= '0;
            bl_q     <= '0;
            beat_cnt <= '0;
            idx_q    <= '0;
            ptr      <= PTR_W'(N_PORTS - 1);
            err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (any_req) begin
                    gnt      <= win;
                    idx_q    <= win_idx;
                    instr_q  <= we[win_idx] ? MEM_INSTR_WR : MEM_INSTR_RD;
                    addr_q   <= addr[int'(win_idx)*ADDR_W +: ADDR_W];
                    bl_q     <= bl[int'(win_idx)*BL_W +: BL_W];
                    beat_cnt <= bl[int'(win_idx)*BL_W +: BL_W];
                    state    <= we[win_idx] ? S_WDATA : S_ISSUE;
                end
                S_WDATA: if (mem_wr_beat) begin
                    if (beat_cnt == '0) state <= S_ISSUE;
                    else                beat_cnt <= beat_cnt - 1'b1;
                end
                S_ISSUE: if (!mem_cmd_full) begin
                    if (instr_q == MEM_INSTR_WR) begin
                        state <= S_DONE;
                    end else begin
                        state    <= S_RDATA;
                        beat_cnt <= bl_q;
                    end
                end
                S_RDATA: if (mem_rd_beat) begin
                    if (beat_cnt == '0) state <= S_DONE;
                    else                beat_cnt <= beat_cnt - 1'b1;
                end
                S_DONE: begin
                    gnt   <= '0;
                    ptr   <= idx_q;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            if (beat_err) err <= 1'b1;
        end
    end

    assign done          = (state == S_DONE) ? gnt : '0;
    assign mem_cmd_en    = (state == S_ISSUE) && !mem_cmd_full;
    assign mem_cmd_instr = instr_q;
    assign mem_cmd_addr  = addr_q;
    assign mem_cmd_bl    = bl_q;
    assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized bursts, all judged against a transaction-level expectation.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int BW = 6;
    localparam int P0 = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, we;
    logic [N*AW-1:0] addr;
    logic [N*BW-1:0] bl;
    logic [N-1:0]    gnt, done;
    logic            mem_cmd_en;
    logic [2:0]      mem_cmd_instr;
    logic [AW-1:0]   mem_cmd_addr;
    logic [BW-1:0]   mem_cmd_bl;
    logic            mem_cmd_full, mem_wr_beat, mem_rd_beat;
    logic            busy, err;

    int n_cmp = 0;
    int n_bad = 0;
    int last_served = N - 1;

    always #5 clk = ~clk;

    mem_port_arbiter #(.N_PORTS(N), .ADDR_W(AW), .BL_W(BW), .PRIO0(P0)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .we            (we),
        .addr          (addr),
        .bl            (bl),
        .gnt           (gnt),
        .done          (done),
        .mem_cmd_en    (mem_cmd_en),
        .mem_cmd_instr (mem_cmd_instr),
        .mem_cmd_addr  (mem_cmd_addr),
        .mem_cmd_bl    (mem_cmd_bl),
        .mem_cmd_full  (mem_cmd_full),
        .mem_wr_beat   (mem_wr_beat),
        .mem_rd_beat   (mem_rd_beat),
        .busy          (busy),
        .err           (err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        return N'(1) << i;
    endfunction

    function automatic int gnt_index(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    // Fixed priority for port 0, otherwise the next requester after the last one served.
    function automatic int model_pick(input logic [N-1:0] r);
        if (P0 != 0 && r[PORT_CMD]) return PORT_CMD;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last_served + k) % N;
            if (r[idx] && !(P0 != 0 && idx == PORT_CMD)) return idx;
        end
        return -1;
    endfunction

    task automatic set_port(input int p, input logic w, input logic [AW-1:0] a, input logic [BW-1:0] b);
        req[p] = 1'b1;
        we[p]  = w;
        addr[p*AW +: AW] = a;
        bl[p*BW +: BW]   = b;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},   gnt, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_cmden"}, mem_cmd_en, 0);
        check({tag, "_instr"}, mem_cmd_instr, 0);
        check({tag, "_addr"},  mem_cmd_addr, 0);
        check({tag, "_bl"},    mem_cmd_bl, 0);
        check({tag, "_busy"},  busy, 0);
    endtask

    // Entered at an idle negedge with requests already driven; leaves at the idle negedge after release.
    task automatic serve_burst(input int full_cycles, input bit mutate, output int got_w);
        int            exp_w, gaps;
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic [BW-1:0] exp_bl;
        exp_w    = model_pick(req);
        exp_we   = we[exp_w];
        exp_addr = addr[exp_w*AW +: AW];
        exp_bl   = bl[exp_w*BW +: BW];
        tick(); #1;
        got_w = gnt_index(gnt);
        check("gnt", gnt, onehot(exp_w));
        check("busy", busy, 1);
        if (mutate) begin
            addr[exp_w*AW +: AW] = $urandom;
            bl[exp_w*BW +: BW]   = BW'($urandom);
            if ($urandom_range(0, 1) == 1) req[exp_w] = 1'b0;
        end
        if (exp_we) begin
            for (int b = 0; b <= int'(exp_bl); b++) begin
                gaps = $urandom_range(0, 2);
                for (int g = 0; g < gaps; g++) begin
                    mem_wr_beat = 1'b0; #1;
                    check("cmd_en_wgap", mem_cmd_en, 0);
                    tick();
                end
                mem_wr_beat = 1'b1; #1;
                check("cmd_en_wbeat", mem_cmd_en, 0);
                tick();
            end
            mem_wr_beat = 1'b0;
        end
        for (int f = 0; f < full_cycles; f++) begin
            mem_cmd_full = 1'b1; #1;
            check("cmd_en_full", mem_cmd_en, 0);
            tick();
        end
        mem_cmd_full = 1'b0; #1;
        check("cmd_en", mem_cmd_en, 1);
        check("cmd_instr", mem_cmd_instr, exp_we ? 3'b000 : 3'b001);
        check("cmd_addr", mem_cmd_addr, exp_addr);
        check("cmd_bl", mem_cmd_bl, exp_bl);
        tick();
        if (!exp_we) begin
            for (int b = 0; b <= int'(exp_bl); b++) begin
                gaps = $urandom_range(0, 2);
                for (int g = 0; g < gaps; g++) begin
                    mem_rd_beat = 1'b0; #1;
                    check("done_rgap", done, 0);
                    tick();
                end
                mem_rd_beat = 1'b1; #1;
                check("cmd_en_rbeat", mem_cmd_en, 0);
                tick();
            end
            mem_rd_beat = 1'b0;
        end
        #1;
        check("done", done, onehot(exp_w));
        check("gnt_held", gnt, onehot(exp_w));
        check("cmd_en_done", mem_cmd_en, 0);
        tick(); #1;
        check("done_clear", done, 0);
        check("gnt_clear", gnt, 0);
        check("busy_clear", busy, 0);
        check("err_clean", err, 0);
        last_served = exp_w;
    endtask

    initial begin
        int w;
        int exp_order[6] = '{1, 2, 3, 1, 2, 3};
        rst = 1'b1;
        req = '0; we = '0; addr = '0; bl = '0;
        mem_cmd_full = 1'b0; mem_wr_beat = 1'b0; mem_rd_beat = 1'b0;
        repeat (3) tick();
        #1;
        check_all_zero("reset");
        check("reset_err", err, 0);
        rst = 1'b0;

        // Single read on the data port.
        set_port(PORT_DATA, 1'b0, 32'h000A_0000, 6'd3);
        serve_burst(0, 1'b0, w);
        req = '0;

        // Write-back burst: command only after both write beats.
        set_port(PORT_WB, 1'b1, 32'h1234_5678, 6'd1);
        serve_burst(0, 1'b0, w);
        req = '0;

        // Round-robin among ports 1..3.
        for (int p = 1; p < N; p++) set_port(p, 1'b0, 32'h100 * p, 6'd0);
        for (int i = 0; i < 6; i++) begin
            serve_burst(0, 1'b0, w);
            check("rr_order", w, exp_order[i]);
        end

        // Port 0 holds top priority while it requests.
        set_port(PORT_CMD, 1'b0, 32'hC0DE_0000, 6'd0);
        for (int i = 0; i < 3; i++) begin
            serve_burst(0, 1'b0, w);
            check("prio0", w, PORT_CMD);
        end
        req = '0;

        // Command FIFO full for five cycles.
        set_port(PORT_WGT, 1'b0, 32'hBEEF_0040, 6'd2);
        serve_burst(5, 1'b0, w);
        req = '0;

        // Reset mid-read, then a stray read beat while idle.
        set_port(PORT_DATA, 1'b0, 32'h0000_8000, 6'd7);
        tick(); #1;
        check("r6_gnt", gnt, onehot(PORT_DATA));
        req = '0;
        tick();
        mem_rd_beat = 1'b1; tick();
        mem_rd_beat = 1'b1; tick();
        mem_rd_beat = 1'b0; rst = 1'b1;
        tick(); #1;
        check_all_zero("midrst");
        rst = 1'b0;
        last_served = N - 1;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            check("midrst_nodone", done, 0);
        end
        mem_rd_beat = 1'b1;
        tick();
        mem_rd_beat = 1'b0; #1;
        check("stray_err", err, 1);
        repeat (4) tick();
        #1;
        check("err_sticky", err, 1);
        check("stray_busy", busy, 0);
        rst = 1'b1;
        tick(); #1;
        check("err_rst", err, 0);
        rst = 1'b0;

        // Randomized traffic, including the longest burst.
        for (int t = 0; t < 60; t++) begin
            if (req == '0 && $urandom_range(0, 3) == 0) begin
                tick(); #1;
                check("idle_gnt", gnt, 0);
                check("idle_busy", busy, 0);
            end
            for (int p = 0; p < N; p++) begin
                if (!req[p] && $urandom_range(0, 1) == 1)
                    set_port(p, 1'($urandom_range(0, 1)), $urandom,
                             ($urandom_range(0, 9) == 0) ? 6'd63 : BW'($urandom_range(0, 4)));
            end
            if (req == '0)
                set_port($urandom_range(0, N - 1), 1'($urandom_range(0, 1)), $urandom,
                         BW'($urandom_range(0, 4)));
            serve_burst($urandom_range(0, 3), 1'b1, w);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
